// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one N-bit load-enabled register among R writers.
// Define REG_ARB_LOCK_EN to add the lock_i port for grant-hold write bursts.
module reg_share_arbiter #(
  parameter int N = 8,
  parameter int R = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [R-1:0]         req_i,
  input  logic [R*N-1:0]       wdata_i,
`ifdef REG_ARB_LOCK_EN
  input  logic [R-1:0]         lock_i,
`endif
  output logic [R-1:0]         gnt_o,
  output logic [N-1:0]         q_o,
  output logic [$clog2(R)-1:0] owner_o,
  output logic                 busy_o
);
  localparam int PW = $clog2(R);

  // state | meaning
  // IDLE  | no grant outstanding, gnt_q == 0
  // GRANT | exactly one gnt_q bit set
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [R-1:0]  gnt_q, gnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  q_q, q_d;
  logic [PW-1:0] owner_q, owner_d;

  logic [PW-1:0] cur_idx, base, win, sidx;
  logic [R-1:0]  cand;
  logic          found, hold, wr_en;

  always_comb begin
    cur_idx = '0;
    for (int i = 0; i < R; i++) begin
      if (gnt_q[i]) cur_idx = PW'(i);
    end
    wr_en = (state_q == GRANT) && req_i[cur_idx];
`ifdef REG_ARB_LOCK_EN
    hold = wr_en && lock_i[cur_idx];
`else
    hold = 1'b0;
`endif
    // The requester granted this cycle is already the "last granted" one for the search.
    base  = (state_q == GRANT) ? cur_idx : ptr_q;
    cand  = req_i & ~gnt_q;
    found = 1'b0;
    win   = '0;
    sidx  = '0;
    for (int k = 1; k <= R; k++) begin
      sidx = PW'((int'(base) + k) % R);
      if (!found && cand[sidx]) begin
        found = 1'b1;
        win   = sidx;
      end
    end

    if (hold) begin
      gnt_d   = gnt_q;
      state_d = GRANT;
    end else if (found) begin
      gnt_d   = R'(1) << win;
      state_d = GRANT;
    end else begin
      gnt_d   = '0;
      state_d = IDLE;
    end

    ptr_d   = (state_q == GRANT) ? cur_idx : ptr_q;
    q_d     = wr_en ? wdata_i[int'(cur_idx)*N +: N] : q_q;
    owner_d = wr_en ? cur_idx : owner_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= PW'(R - 1);
      q_q     <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      q_q     <= q_d;
      owner_q <= owner_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign q_o     = q_q;
  assign owner_o = owner_q;
  assign busy_o  = |gnt_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter: a queue-based reference model predicts grant,
// register contents and owner every cycle; a negedge monitor pops and compares.
module tb_reg_share_arbiter;
  localparam int N  = 8;
  localparam int R  = 4;
  localparam int PW = $clog2(R);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [R-1:0]   req = '0;
  logic [R-1:0]   lock = '0;
  logic [R*N-1:0] wdata = '0;
  logic [R-1:0]   gnt;
  logic [N-1:0]   q;
  logic [PW-1:0]  owner;
  logic           busy;

  always #5 clk = ~clk;

  reg_share_arbiter #(.N(N), .R(R)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .wdata_i (wdata),
`ifdef REG_ARB_LOCK_EN
    .lock_i  (lock),
`endif
    .gnt_o   (gnt),
    .q_o     (q),
    .owner_o (owner),
    .busy_o  (busy)
  );

  typedef struct packed {
    logic [R-1:0]  g;
    logic [N-1:0]  q;
    logic [PW-1:0] own;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: who holds the grant now, who was granted last, register image.
  int         m_g, m_last, m_own, prev_g;
  logic [N-1:0] m_q;
  bit         rnd_en = 0;
  logic [R-1:0] wd_mask = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_g = -1; m_last = R - 1; m_own = 0; m_q = '0; prev_g = -1;
  endtask

  task automatic model_step();
    int  ng;
    bit  hold;
    exp_t e;
    if (m_g >= 0) begin
      if (req[m_g]) begin
        m_q   = wdata[m_g*N +: N];
        m_own = m_g;
      end
      m_last = m_g;
    end
    hold = 0;
`ifdef REG_ARB_LOCK_EN
    if (m_g >= 0 && req[m_g] && lock[m_g]) hold = 1;
`endif
    ng = -1;
    if (hold) ng = m_g;
    else begin
      for (int k = 1; k <= R; k++) begin
        int c;
        c = (m_last + k) % R;
        if (ng < 0 && req[c] && c != m_g) ng = c;
      end
    end
    prev_g = m_g;
    m_g    = ng;
    e.g    = (ng < 0) ? '0 : (R'(1) << ng);
    e.q    = m_q;
    e.own  = PW'(m_own);
    sb.push_back(e);
  endtask

  // One clock: model the edge, then let the requesters react per the handshake.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < R; i++) begin
      if (prev_g == i && req[i] && !lock[i]) req[i] = 1'b0;
      if (m_g == i && (wd_mask[i] || (rnd_en && $urandom_range(9) == 0))) req[i] = 1'b0;
      wd_mask[i] = 1'b0;
      if (!req[i]) wdata[i*N +: N] = N'($urandom);
      if (rnd_en && !req[i] && prev_g != i && m_g != i && $urandom_range(2) == 0)
        req[i] = 1'b1;
    end
  endtask

  task automatic reset_dut();
    #2;
    rst = 1'b1;
    sb.delete();
    model_reset();
    req = '0; lock = '0;
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_gnt",   32'(gnt),   32'(e.g));
      chk("sb_q",     32'(q),     32'(e.q));
      chk("sb_owner", 32'(owner), 32'(e.own));
      chk("sb_busy",  32'(busy),  32'(|e.g));
    end
  end

  initial begin
    model_reset();
    req   = R'($urandom);
    wdata = {$urandom, $urandom};
    #1 rst = 1'b1;
    #2;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #3;
    req = '0;
    rst = 1'b0;

    // single request on requester 2
    req = 4'b0100;
    wdata[2*N +: N] = 8'hA5;
    cycle();
    chk("single_gnt", 32'(gnt), 32'h4);
    cycle();
    chk("single_q", 32'(q), 32'hA5);
    chk("single_owner", 32'(owner), 2);
    chk("single_idle", 32'(gnt), 0);
    cycle();

    // all four contend from reset
    reset_dut();
    req = 4'b1111;
    for (int i = 0; i < R; i++) wdata[i*N +: N] = N'(8'h30 + i);
    for (int i = 0; i < 6; i++) cycle();
    chk("cont_q", 32'(q), 32'h33);
    chk("cont_owner", 32'(owner), 3);

    // requester 1 withdraws during its grant
    req = 4'b0010;
    wd_mask = 4'b0010;
    cycle();
    chk("wd_gnt", 32'(gnt), 32'h2);
    cycle();
    chk("wd_q", 32'(q), 32'h33);
    chk("wd_owner", 32'(owner), 3);
    req = 4'b1011;
    for (int i = 0; i < 5; i++) cycle();

    // reset while requester 1 holds the grant
    req = 4'b0010;
    wdata[N +: N] = 8'h5C;
    begin
      int w = 0;
      while (m_g != 1 && w < 8) begin cycle(); w++; end
    end
    chk("midrst_pre_gnt", 32'(gnt), 32'h2);
    #2;
    rst = 1'b1;
    sb.delete();
    model_reset();
    #1;
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_q", 32'(q), 0);
    chk("midrst_owner", 32'(owner), 0);
    chk("midrst_busy", 32'(busy), 0);
    req = '0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    req = 4'b0010;
    cycle();
    chk("midrst_regnt", 32'(gnt), 32'h2);
    cycle();
    cycle();

    // randomized traffic
    rnd_en = 1;
    for (int i = 0; i < 400; i++) cycle();
    rnd_en = 0;
    req = '0;
    for (int i = 0; i < 4; i++) cycle();

`ifdef REG_ARB_LOCK_EN
    reset_dut();
    req = 4'b0011;
    lock = 4'b0001;
    wdata[0 +: N] = 8'h11;
    cycle();
    cycle();
    wdata[0 +: N] = 8'h22;
    cycle();
    wdata[0 +: N] = 8'h33;
    lock = '0;
    cycle();
    chk("lock_q", 32'(q), 32'h33);
    chk("lock_gnt", 32'(gnt), 32'h2);
    for (int i = 0; i < 4; i++) cycle();
`endif

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
